// File: rtl/fm_sample_scheduler.sv
// fm_sample_scheduler: buffers unsigned UART audio bytes in a small FIFO and
// releases them as signed samples on a fixed-rate tick. It handles prefill
// before playback, underrun (silence and return to prefill) and overflow
// (sticky flag; the byte is dropped).
module fm_sample_scheduler #(
  parameter int CLK_DIV = 7812,
  parameter int DEPTH   = 16,
  parameter int PREFILL = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [7:0]               i_dat,
  input  logic                     i_dat_vld,
  output logic [7:0]               o_sample,
  output logic                     o_sample_stb,
  output logic                     o_playing,
  output logic                     o_overflow,
  output logic [15:0]              o_underrun_cnt,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [CW-1:0] CNT_MAX     = CW'(CLK_DIV - 1);
  localparam logic [LW-1:0] FULL_LVL    = LW'(DEPTH);
  localparam logic [LW-1:0] PREFILL_LVL = LW'(PREFILL);
  localparam logic [LW-1:0] LVL_ONE     = LW'(1);
  localparam logic [AW-1:0] PTR_ONE     = AW'(1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PLAY = 1'b1} state_e;

  // Unsigned byte to signed sample: subtracting 128 is a flip of the MSB.
  function automatic logic [7:0] to_signed_sample(input logic [7:0] b);
    return b ^ 8'h80;
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  state_e        state_q, state_d;
  logic [7:0]    sample_q, sample_d;
  logic          stb_q, stb_d;
  logic [15:0]   ucnt_q, ucnt_d;

  logic tick_s, full_s, pop_s, wr_acc_s;
  logic [7:0] head_s;

  // Tick fires on the last count of each audio sample period; no bypass of
  // same-cycle writes, so pop decisions use the registered level only.
  assign tick_s   = (cnt_q == CNT_MAX);
  assign cnt_d    = tick_s ? {CW{1'b0}} : cnt_q + CW'(1);
  assign full_s   = (level_q == FULL_LVL);
  assign head_s   = mem_q[rd_ptr_q];
  assign pop_s    = tick_s && (((state_q == ST_IDLE) && (level_q >= PREFILL_LVL)) ||
                               ((state_q == ST_PLAY) && (level_q != {LW{1'b0}})));
  // A write into a full FIFO still fits when the head leaves in the same cycle.
  assign wr_acc_s = i_dat_vld && (!full_s || pop_s);
  assign wr_ptr_d = wr_acc_s ? wr_ptr_q + PTR_ONE : wr_ptr_q;
  assign rd_ptr_d = pop_s ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  assign overflow_d = overflow_q | (i_dat_vld & full_s & ~pop_s);

  // Occupancy update: +1 on accepted write, -1 on pop, unchanged on both.
  always_comb begin
    level_d = level_q;
    case ({wr_acc_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Free-running sample-rate divider.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      level_q    <= {LW{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents are meaningless after reset since pointers clear.
  always_ff @(posedge i_clk) begin
    if (wr_acc_s) begin
      mem_q[wr_ptr_q] <= i_dat;
    end
  end

  // Playback state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: start playing on a prefilled tick, stop on an empty tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (tick_s && pop_s) state_d = ST_PLAY;
        else                 state_d = ST_IDLE;
      end
      ST_PLAY: begin
        if (tick_s && !pop_s) state_d = ST_IDLE;
        else                  state_d = ST_PLAY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next-values: every tick strobes a sample, silence when nothing pops.
  always_comb begin
    sample_d = sample_q;
    stb_d    = 1'b0;
    ucnt_d   = ucnt_q;
    if (tick_s) begin
      stb_d = 1'b1;
      if (pop_s) begin
        sample_d = to_signed_sample(head_s);
      end else begin
        sample_d = 8'h00;
        if ((state_q == ST_PLAY) && (ucnt_q != 16'hFFFF)) begin
          ucnt_d = ucnt_q + 16'd1;
        end else begin
          ucnt_d = ucnt_q;
        end
      end
    end else begin
      sample_d = sample_q;
      stb_d    = 1'b0;
    end
  end

  // Registered sample outputs and underrun counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sample_q <= 8'h00;
      stb_q    <= 1'b0;
      ucnt_q   <= 16'd0;
    end else begin
      sample_q <= sample_d;
      stb_q    <= stb_d;
      ucnt_q   <= ucnt_d;
    end
  end

  assign o_sample       = sample_q;
  assign o_sample_stb   = stb_q;
  assign o_playing      = (state_q == ST_PLAY);
  assign o_overflow     = overflow_q;
  assign o_underrun_cnt = ucnt_q;
  assign o_level        = level_q;

endmodule
